// File: rtl/spi_master_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : spi_master_arbiter
//  Purpose  : Round-robin owner of a single spi_core byte engine. Grants the
//             core to one requester for a whole burst, keeps that requester's
//             slave select low across bytes, walks the core cs/wr/done
//             handshake per byte and hands each received byte back.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_master_arbiter #(
  parameter int DWIDTH    = 8,
  parameter int NREQ      = 2,
  parameter int SETUP_CYC = 2,
  parameter int HOLD_CYC  = 2,
  parameter int GAP_CYC   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DWIDTH-1:0] req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DWIDTH-1:0]      rsp_data,
  output logic [NREQ-1:0]        grant,
  output logic [NREQ-1:0]        ss_n,
  output logic                   busy,
  output logic                   core_cs,
  output logic                   core_wr,
  output logic                   core_rd,
  output logic [DWIDTH-1:0]      core_din,
  input  logic [DWIDTH-1:0]      core_dout,
  input  logic                   core_done
);

  localparam int               c_IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [c_IW-1:0]  c_LAST_RST = c_IW'(NREQ - 1);
  localparam logic [NREQ-1:0]  c_ONE      = NREQ'(1);
  localparam logic [7:0]       c_SETUP_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0]       c_HOLD_LD  = 8'(HOLD_CYC - 1);
  localparam logic [7:0]       c_GAP_LD   = 8'(GAP_CYC - 1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_SETUP     = 4'd1,
    S_ISSUE     = 4'd2,
    S_WAIT_BUSY = 4'd3,
    S_WAIT_DONE = 4'd4,
    S_RESP      = 4'd5,
    S_NEXT      = 4'd6,
    S_HOLD      = 4'd7,
    S_GAP       = 4'd8
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [c_IW-1:0]   gidx_q, gidx_d;
  logic [c_IW-1:0]   last_grant_q, last_grant_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   ss_n_q, ss_n_d;
  logic              last_flag_q, last_flag_d;
  logic [DWIDTH-1:0] rsp_data_q, rsp_data_d;

  logic              pick_found;
  logic [c_IW-1:0]   pick_idx;
  logic [c_IW:0]     scan_idx;

  // Round-robin search: first valid requester after the previous owner.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_idx = {1'b0, last_grant_q} + (c_IW+1)'(k);
      if (scan_idx >= (c_IW+1)'(NREQ)) begin
        scan_idx = scan_idx - (c_IW+1)'(NREQ);
      end
      if (!pick_found && req_valid[scan_idx[c_IW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx[c_IW-1:0];
      end
    end
  end

  // Next-state logic for the burst sequencer.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gidx_d       = gidx_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    ss_n_d       = ss_n_q;
    last_flag_d  = last_flag_q;
    rsp_data_d   = rsp_data_q;
    case (state_q)
      S_IDLE: begin
        // A core still finishing a byte (e.g. after a reset) blocks arbitration.
        if (core_done && pick_found) begin
          gidx_d  = pick_idx;
          grant_d = c_ONE << pick_idx;
          ss_n_d  = ~(c_ONE << pick_idx);
          cnt_d   = c_SETUP_LD;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == 8'd0) begin
          state_d = req_valid[gidx_q] ? S_ISSUE : S_NEXT;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_ISSUE: begin
        last_flag_d = req_last[gidx_q];
        state_d     = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!core_done) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (core_done) begin
          rsp_data_d = core_dout;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        if (last_flag_q) begin
          cnt_d   = c_HOLD_LD;
          state_d = S_HOLD;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        // Burst stays locked to its owner until its next byte shows up.
        if (req_valid[gidx_q]) begin
          state_d = S_ISSUE;
        end
      end
      S_HOLD: begin
        if (cnt_q == 8'd0) begin
          ss_n_d       = '1;
          grant_d      = '0;
          last_grant_d = gidx_q;
          cnt_d        = c_GAP_LD;
          state_d      = S_GAP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == 8'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      gidx_q       <= '0;
      last_grant_q <= c_LAST_RST;
      grant_q      <= '0;
      ss_n_q       <= '1;
      last_flag_q  <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gidx_q       <= gidx_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      ss_n_q       <= ss_n_d;
      last_flag_q  <= last_flag_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  // Strobes are decoded from the state so they are exactly one cycle wide.
  always_comb begin
    req_ready = (state_q == S_ISSUE) ? grant_q : '0;
    rsp_valid = (state_q == S_RESP)  ? grant_q : '0;
    core_cs   = (state_q == S_ISSUE);
    core_wr   = (state_q == S_ISSUE);
    core_din  = (state_q == S_ISSUE) ? req_data[gidx_q*DWIDTH +: DWIDTH] : '0;
  end

  assign core_rd  = 1'b0;
  assign busy     = (state_q != S_IDLE);
  assign grant    = grant_q;
  assign ss_n     = ss_n_q;
  assign rsp_data = rsp_data_q;

endmodule
`default_nettype wire
